// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  // Controller states: waiting for operands, rippling bits, holding result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = i_a - i_b - i_bin, with borrow out.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_ab_xor;

  assign w_ab_xor = i_a ^ i_b;

  // Difference bit and borrow generated when the minuend bit cannot cover
  // the subtrahend bit plus the incoming borrow.
  always_comb begin
    o_d    = w_ab_xor ^ i_bin;
    o_bout = (~i_a & i_b) | (~w_ab_xor & i_bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: a - b computed LSB first, one bit
// per clock, through a single full_subtractor cell.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready/out_valid are decoded from the state register only,
// so neither depends combinationally on the partner's valid/ready. Once
// out_valid is high, diff/borrow_out stay stable until the transfer.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow_out,
  output sub_state_t            o_dbg_state
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  sub_state_t            r_state;
  sub_state_t            w_next_state;
  logic [DATA_WIDTH-1:0] r_a_sh;
  logic [DATA_WIDTH-1:0] r_b_sh;
  logic [DATA_WIDTH-1:0] r_diff;
  logic                  r_borrow;
  logic [CW-1:0]         r_cnt;
  logic                  w_d;
  logic                  w_bout;

  full_subtractor u_fs (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: accept in IDLE, ripple DATA_WIDTH bits, wait for sink.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)           w_next_state = SHIFT;
      SHIFT:   if (r_cnt == LAST_BIT)  w_next_state = DONE;
      DONE:    if (out_ready)          w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then shift one bit per SHIFT edge.
  // diff/borrow are left untouched in IDLE and DONE so the last result persists.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_diff   <= {w_d, r_diff[DATA_WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign diff        = r_diff;
  assign borrow_out  = r_borrow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (DATA_WIDTH = 8).
module tb_serial_subtractor;

  localparam int W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  serial_subtractor #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .borrow_out  (borrow_out),
    .o_dbg_state (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // {borrow, diff} of an unsigned subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x - y;
    return {(x < y), d};
  endfunction

  // Scoreboard: at most one operation in flight; age counts edges since accept.
  logic [W:0] exp_q[$];
  int         age = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      age = 0;
    end else if (exp_q.size() != 0) begin
      if (age >= W && out_ready) begin
        void'(exp_q.pop_front());
      end else begin
        age++;
      end
    end else if (in_valid) begin
      exp_q.push_back(ref_sub(a, b));
      age = 0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow_out, 0);
    end else begin
      if (exp_q.size() != 0 && age >= W) begin
        chk("out_valid", out_valid, 1);
        chk("diff", diff, exp_q[0][W-1:0]);
        chk("borrow_out", borrow_out, exp_q[0][W]);
      end else begin
        chk("out_valid", out_valid, 0);
      end
      chk("in_ready", in_ready, exp_q.size() == 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Present operands until accepted; called at posedge+#1, returns at posedge+#1.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      if (in_ready) ok = 1;
    end
    #1;
    if (!keep) in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 40 cycles at %0t", $time);
    end
  endtask

  // Wait for out_valid (bounded) and check against literal expectations.
  task automatic get_result(input logic [W-1:0] ed, input logic eb, input string name,
                            output int lat);
    bit seen;
    seen = 0;
    lat = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        lat = i;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no out_valid expected out_valid within 60 cycles", name);
    end else begin
      chk({name, "_diff"}, diff, ed);
      chk({name, "_borrow"}, borrow_out, eb);
    end
  endtask

  // One full transaction with out_ready held high.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] ed, input logic eb, input string name);
    int lat;
    send(x, y, 0);
    get_result(ed, eb, name, lat);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, lat2;
    logic [W-1:0] x, y;
    logic [W:0]   r;
    int stall;

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic subtraction and latency from accept edge.
    send(8'h05, 8'h03, 0);
    get_result(8'h02, 1'b0, "sub_05_03", lat);
    chk("latency", lat, W);
    @(posedge clk);
    #1;
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, "sub_03_05");
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, "sub_00_01");
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, "sub_00_FF");

    // Back-to-back with in_valid held high.
    send(8'hFF, 8'hFF, 1);
    fork
      send(8'h80, 8'h7F, 0);
      get_result(8'h00, 1'b0, "b2b_first", lat);
    join
    get_result(8'h01, 1'b0, "b2b_second", lat2);
    chk("b2b_second_latency", lat2, W);
    @(posedge clk);
    #1;

    // Backpressure: result frozen while out_ready is low.
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 0);
    get_result(8'h4B, 1'b0, "stall", lat);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold_diff", diff, 8'h4B);
      chk("stall_hold_borrow", borrow_out, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_in_ready", in_ready, 1);
    chk("stall_release_out_valid", out_valid, 0);
    chk("stall_keep_diff", diff, 8'h4B);
    @(posedge clk);
    #1;

    // Reset in the 4th SHIFT cycle.
    send(8'h33, 8'h11, 0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    do_op(8'h10, 8'h20, 8'hF0, 1'b1, "after_abort");

    // Operand changes and in_valid pulses during SHIFT are ignored.
    send(8'hC3, 8'h3C, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      a = W'($urandom);
      b = W'($urandom);
      in_valid = ~in_valid;
    end
    in_valid = 1'b0;
    get_result(8'h87, 1'b0, "shift_ignore", lat);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and idle gaps.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0:       begin x = '0;          y = W'($urandom); end
        1:       begin x = W'($urandom); y = '1;          end
        2:       begin x = W'($urandom); y = x;           end
        default: begin x = W'($urandom); y = W'($urandom); end
      endcase
      r = ref_sub(x, y);
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      send(x, y, 0);
      get_result(r[W-1:0], r[W], "rand", lat);
      if (stall != 0) begin
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected completion before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
